// File: rtl/mbscore_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : mbscore_fetch_queue
// Purpose  : Instruction prefetch unit. It keeps a fetch PC, issues single
//            outstanding requests to instruction memory, and buffers the
//            returned words with their PCs in a circular queue for decode.
//            It also handles redirects from decode, interrupt entry and
//            exception return (eret).
//
// Ports    : clk, rst          - clock; synchronous active-high reset
//            mem_req/mem_addr  - request and address to instruction memory
//            mem_ack/mem_data  - memory acknowledge and returned instruction
//            inst_valid        - queue is non-empty
//            inst_out/pc_out   - head instruction and its PC
//            deq               - decode consumes the head entry
//            redirect_valid    - branch/jump target from decode is valid
//            redirect_addr     - branch/jump target (forced word aligned)
//            int_req           - interrupt request (taken only when int_en)
//            eret              - return from exception to epc
//            hlt               - stops new fetches only
//            epc_out           - saved exception PC
//            int_en            - interrupts enabled
//
// Revision : 1.0 - initial release
// ============================================================================
module mbscore_fetch_queue #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [ADDR_WIDTH-1:0] INT_VECTOR = 32'h0000_0080
) (
    input  logic                  clk,
    input  logic                  rst,

    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_data,

    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    input  logic                  deq,

    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,

    input  logic                  int_req,
    input  logic                  eret,
    input  logic                  hlt,
    output logic [ADDR_WIDTH-1:0] epc_out,
    output logic                  int_en
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int                    c_PTR_W     = $clog2(DEPTH);
    localparam int                    c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]    c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_PC_STEP   = ADDR_WIDTH'(4);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] r_fpc;
    logic [ADDR_WIDTH-1:0] r_epc;
    logic                  r_int_en;

    // r_pending is the single outstanding request; it is also mem_req.
    logic                  r_pending;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    // r_discard marks the outstanding request as stale after a flush.
    logic                  r_discard;

    logic [ADDR_WIDTH-1:0] r_q_pc   [DEPTH];
    logic [DATA_WIDTH-1:0] r_q_inst [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    // Last presented head, shown while the queue is empty.
    logic [ADDR_WIDTH-1:0] r_last_pc;
    logic [DATA_WIDTH-1:0] r_last_inst;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic                  w_inst_valid;
    logic [ADDR_WIDTH-1:0] w_head_pc;
    logic [DATA_WIDTH-1:0] w_head_inst;
    logic                  w_mem_fire;
    logic                  w_take_int;
    logic                  w_take_redir;
    logic                  w_take_eret;
    logic                  w_flush;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic [ADDR_WIDTH-1:0] w_redir_pc;
    logic [ADDR_WIDTH-1:0] w_fpc_next;
    logic                  w_unused_redirect_lsbs;

    assign w_inst_valid = (r_count != '0);
    assign w_head_pc    = r_q_pc[r_rd_ptr];
    assign w_head_inst  = r_q_inst[r_rd_ptr];

    // Redirect targets are forced to word alignment; the low bits are
    // intentionally ignored.
    assign w_redir_pc             = {redirect_addr[ADDR_WIDTH-1:2], 2'b00};
    assign w_unused_redirect_lsbs = ^redirect_addr[1:0];

    always_comb begin
        w_mem_fire   = r_pending & mem_ack;

        // Only the highest-priority flush event acts in a cycle. An
        // interrupt seen while disabled is simply dropped, never held.
        w_take_int   = int_req & r_int_en;
        w_take_redir = redirect_valid & ~w_take_int;
        w_take_eret  = eret & ~w_take_int & ~redirect_valid;
        w_flush      = w_take_int | w_take_redir | w_take_eret;

        // Returned data is kept only if the request is still current and
        // no flush coincides with its acknowledge.
        w_push       = w_mem_fire & ~r_discard & ~w_flush;
        w_pop        = deq & w_inst_valid & ~w_flush;

        // New request: nothing outstanding, room in the queue, not halted
        // and no flush this cycle (the new fpc is used one cycle later).
        w_issue      = ~r_pending & (r_count < c_DEPTH_CNT) & ~hlt & ~w_flush;

        w_fpc_next   = r_fpc;
        if (w_take_int) begin
            w_fpc_next = INT_VECTOR;
        end else if (w_take_redir) begin
            w_fpc_next = w_redir_pc;
        end else if (w_take_eret) begin
            w_fpc_next = r_epc;
        end else if (w_push) begin
            w_fpc_next = r_fpc + c_PC_STEP;
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpc       <= RESET_PC;
            r_epc       <= '0;
            r_int_en    <= 1'b1;
            r_pending   <= 1'b0;
            r_mem_addr  <= RESET_PC;
            r_discard   <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_last_pc   <= '0;
            r_last_inst <= '0;
        end else begin
            r_fpc <= w_fpc_next;

            if (w_take_int) begin
                // Resume point is the oldest unexecuted instruction, or
                // the next fetch address when nothing is buffered.
                r_epc    <= w_inst_valid ? w_head_pc : r_fpc;
                r_int_en <= 1'b0;
            end else if (w_take_eret) begin
                r_int_en <= 1'b1;
            end

            // Memory handshake: the request holds its address until ack.
            if (w_mem_fire) begin
                r_pending <= 1'b0;
            end else if (w_issue) begin
                r_pending  <= 1'b1;
                r_mem_addr <= r_fpc;
            end

            // A flush with a request in flight (and no ack this cycle)
            // marks that request stale; its ack is swallowed later. A
            // flush coinciding with the ack just drops the data instead.
            if (w_mem_fire) begin
                r_discard <= 1'b0;
            end else if (w_flush && r_pending) begin
                r_discard <= 1'b1;
            end

            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end

            if (w_inst_valid) begin
                r_last_pc   <= w_head_pc;
                r_last_inst <= w_head_inst;
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue storage (no reset needed: entries are read only when valid)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_q_pc[r_wr_ptr]   <= r_mem_addr;
            r_q_inst[r_wr_ptr] <= mem_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_req    = r_pending;
    assign mem_addr   = r_mem_addr;
    assign inst_valid = w_inst_valid;
    assign inst_out   = w_inst_valid ? w_head_inst : r_last_inst;
    assign pc_out     = w_inst_valid ? w_head_pc   : r_last_pc;
    assign epc_out    = r_epc;
    assign int_en     = r_int_en;

endmodule
`default_nettype wire

// File: tb/tb_mbscore_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mbscore_fetch_queue
// Purpose  : Self-checking bench for mbscore_fetch_queue. Directed stimulus
//            pushes expected memory addresses and expected dequeued entries
//            into scoreboards; two monitors pop and compare them whenever
//            the DUT accepts an ack or decode dequeues the head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mbscore_fetch_queue;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        deq;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        int_req;
    logic        eret;
    logic        hlt;
    logic [31:0] epc_out;
    logic        int_en;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_head [$];   // {pc, inst} expected at each dequeue
    logic [31:0] exp_addr [$];   // mem_addr expected at each accepted ack

    mbscore_fetch_queue #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .RESET_PC   (32'h0),
        .INT_VECTOR (32'h0000_0080)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_data       (mem_data),
        .inst_valid     (inst_valid),
        .inst_out       (inst_out),
        .pc_out         (pc_out),
        .deq            (deq),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .int_req        (int_req),
        .eret           (eret),
        .hlt            (hlt),
        .epc_out        (epc_out),
        .int_en         (int_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word stored at an address: distinct from the PC itself.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign mem_data = mdata(mem_addr);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_head(input logic [31:0] pc);
        exp_head.push_back({pc, mdata(pc)});
    endtask

    // Wait (bounded) for a request, then acknowledge it for one cycle.
    task automatic do_ack(input logic [31:0] addr);
        int n = 0;
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        if (!mem_req) begin
            chk("req_timeout", {31'd0, mem_req}, 32'd1);
        end else begin
            exp_addr.push_back(addr);
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
        end
    endtask

    // Monitor: memory accept
    always @(negedge clk) begin
        if (!rst && mem_req && mem_ack) begin
            if (exp_addr.size() == 0) begin
                chk("unexpected_ack_addr", mem_addr, 32'hFFFF_FFFF);
            end else begin
                chk("mem_addr", mem_addr, exp_addr.pop_front());
            end
        end
    end

    // Monitor: dequeue
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && inst_valid && deq) begin
            if (exp_head.size() == 0) begin
                chk("unexpected_deq_pc", pc_out, 32'hFFFF_FFFF);
            end else begin
                e = exp_head.pop_front();
                chk("head_pc", pc_out, e[63:32]);
                chk("head_inst", inst_out, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        mem_ack        = 1'b0;
        deq            = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;
        int_req        = 1'b0;
        eret           = 1'b0;
        hlt            = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) step();
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_mem_req",    {31'd0, mem_req},    32'd0);
        chk("rst_mem_addr",   mem_addr,            32'h0);
        chk("rst_epc",        epc_out,             32'h0);
        chk("rst_int_en",     {31'd0, int_en},     32'd1);
        chk("rst_inst_out",   inst_out,            32'h0);
        chk("rst_pc_out",     pc_out,              32'h0);
        rst = 1'b0;

        // ---------------- fill to four entries ----------------
        for (int i = 0; i < 4; i++) begin
            push_head(32'(i * 4));
            do_ack(32'(i * 4));
        end
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_no_req", {31'd0, mem_req}, 32'd0);
        end
        chk("full_valid", {31'd0, inst_valid}, 32'd1);

        // ---------------- drain with overlapping refill ----------------
        // Heads 0,4,8 pop while ack is held; the refill to 0x10 is accepted
        // on the third pop (push+pop together), then C and 0x10 drain and
        // the queue must be empty.
        push_head(32'h10);
        exp_addr.push_back(32'h10);
        deq     = 1'b1;
        mem_ack = 1'b1;
        repeat (3) step();
        mem_ack = 1'b0;
        repeat (2) step();
        deq = 1'b0;
        chk("drain_empty",    {31'd0, inst_valid}, 32'd0);
        chk("hold_pc_out",    pc_out,              32'h10);
        chk("hold_inst_out",  inst_out,            mdata(32'h10));
        chk("next_req",       {31'd0, mem_req},    32'd1);
        chk("next_req_addr",  mem_addr,            32'h14);

        // ---------------- redirect while request pending ----------------
        redirect_valid = 1'b1;
        redirect_addr  = 32'h103;
        step();
        redirect_valid = 1'b0;
        chk("stale_req_held", {31'd0, mem_req}, 32'd1);
        chk("stale_req_addr", mem_addr,         32'h14);
        step();
        exp_addr.push_back(32'h14);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("discard_no_push", {31'd0, inst_valid}, 32'd0);
        push_head(32'h100);
        do_ack(32'h100);

        // ---------------- hlt with a pending request ----------------
        step();
        chk("req_before_hlt", {31'd0, mem_req}, 32'd1);
        hlt = 1'b1;
        push_head(32'h104);
        do_ack(32'h104);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hlt_no_req", {31'd0, mem_req}, 32'd0);
        end
        hlt = 1'b0;
        push_head(32'h108);
        do_ack(32'h108);
        hlt = 1'b1;
        deq = 1'b1;
        repeat (3) step();
        deq = 1'b0;
        chk("hlt_drained", {31'd0, inst_valid}, 32'd0);

        // ---------------- interrupt / eret ----------------
        redirect_valid = 1'b1;
        redirect_addr  = 32'h20;
        step();
        redirect_valid = 1'b0;
        hlt = 1'b0;
        do_ack(32'h20);
        hlt = 1'b1;
        int_req = 1'b1;
        step();
        int_req = 1'b0;
        chk("int_epc",    epc_out,             32'h20);
        chk("int_en_off", {31'd0, int_en},     32'd0);
        chk("int_flush",  {31'd0, inst_valid}, 32'd0);
        hlt = 1'b0;
        push_head(32'h80);
        do_ack(32'h80);
        hlt = 1'b1;
        int_req = 1'b1;
        step();
        int_req = 1'b0;
        chk("int2_ignored_valid", {31'd0, inst_valid}, 32'd1);
        chk("int2_ignored_epc",   epc_out,             32'h20);
        deq = 1'b1;
        step();
        deq = 1'b0;
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk("eret_int_en", {31'd0, int_en}, 32'd1);
        hlt = 1'b0;
        push_head(32'h20);
        do_ack(32'h20);
        hlt = 1'b1;
        deq = 1'b1;
        step();
        deq = 1'b0;

        // ---------------- address wrap-around ----------------
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        hlt = 1'b0;
        push_head(32'hFFFF_FFFC);
        do_ack(32'hFFFF_FFFC);
        push_head(32'h0);
        do_ack(32'h0);
        hlt = 1'b1;
        deq = 1'b1;
        repeat (2) step();
        deq = 1'b0;
        chk("wrap_drained", {31'd0, inst_valid}, 32'd0);

        // ---------------- flush coinciding with ack ----------------
        hlt = 1'b0;
        step();
        chk("coinc_req",      {31'd0, mem_req}, 32'd1);
        chk("coinc_req_addr", mem_addr,         32'h4);
        exp_addr.push_back(32'h4);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h200;
        mem_ack        = 1'b1;
        step();
        redirect_valid = 1'b0;
        mem_ack        = 1'b0;
        chk("coinc_req_drop", {31'd0, mem_req},    32'd0);
        chk("coinc_no_push",  {31'd0, inst_valid}, 32'd0);
        push_head(32'h200);
        do_ack(32'h200);
        hlt = 1'b1;
        deq = 1'b1;
        step();
        deq = 1'b0;

        repeat (3) step();
        chk("exp_head_left", 32'(exp_head.size()), 32'd0);
        chk("exp_addr_left", 32'(exp_addr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
